// File: rtl/exc_request_unit_if.sv
// Exception request bus between the LEGv8 datapath and the exception request unit.
// The master side drives causes and acknowledges; the slave side returns the request.
interface exc_request_unit_if #(
    parameter int DROP_W = 8
);
    logic              ExtIRQ;
    logic              BadOpcode;
    logic              DMisalign;
    logic              ExcAck;
    logic              ERet;
    logic              Exc;
    logic [3:0]        EStatus;
    logic              InHandler;
    logic              Fatal;
    logic [DROP_W-1:0] IrqDropCnt;

    modport master (
        output ExtIRQ, BadOpcode, DMisalign, ExcAck, ERet,
        input  Exc, EStatus, InHandler, Fatal, IrqDropCnt
    );

    modport slave (
        input  ExtIRQ, BadOpcode, DMisalign, ExcAck, ERet,
        output Exc, EStatus, InHandler, Fatal, IrqDropCnt
    );
endinterface

// File: rtl/exc_request_unit.sv
// Exception request front-end: prioritises external IRQ and precise instruction faults,
// drives Exc/EStatus with an ACK handshake, blocks nesting and escalates nested faults to FATAL.
module exc_request_unit #(
    parameter int DROP_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    exc_request_unit_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_HANDLER = 2'd2,
        ST_FATAL   = 2'd3
    } state_e;

    localparam logic [3:0] CODE_NONE = 4'b0000;
    localparam logic [3:0] CODE_IRQ  = 4'b0001;
    localparam logic [3:0] CODE_BOP  = 4'b0010;
    localparam logic [3:0] CODE_MIS  = 4'b0011;

    localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};
    localparam logic [DROP_W-1:0] DROP_ONE = {{(DROP_W-1){1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [3:0]        cause_q, cause_d;
    logic              irq_pend_q, irq_pend_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              sync1_q, sync2_q, sync2_dly_q;

    logic              irq_edge_s;
    logic [3:0]        win_code_s;
    logic              exc_s;
    logic [3:0]        estatus_s;
    logic              issue_irq_s;

    // Two-flop synchronizer plus one delay stage for edge detection on the synchronized level
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            sync2_dly_q <= 1'b0;
        end else begin
            sync1_q     <= bus.ExtIRQ;
            sync2_q     <= sync1_q;
            sync2_dly_q <= sync2_q;
        end
    end

    assign irq_edge_s = sync2_q & ~sync2_dly_q;

    // Fixed priority among active causes: BadOpcode, then DMisalign, then the pending IRQ
    always_comb begin
        win_code_s = CODE_NONE;
        if (bus.BadOpcode) begin
            win_code_s = CODE_BOP;
        end else if (bus.DMisalign) begin
            win_code_s = CODE_MIS;
        end else if (irq_pend_q) begin
            win_code_s = CODE_IRQ;
        end else begin
            win_code_s = CODE_NONE;
        end
    end

    // Request FSM next-state and output decode
    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        exc_s       = 1'b0;
        estatus_s   = cause_q;
        issue_irq_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                estatus_s = win_code_s;
                if (win_code_s != CODE_NONE) begin
                    exc_s       = 1'b1;
                    cause_d     = win_code_s;
                    issue_irq_s = (win_code_s == CODE_IRQ);
                    if (bus.ExcAck) begin
                        state_d = ST_HANDLER;
                    end else begin
                        state_d = ST_REQ;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                // Code is already committed; later faults cannot change it
                exc_s = 1'b1;
                if (bus.ExcAck) begin
                    state_d = ST_HANDLER;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_HANDLER: begin
                if (bus.BadOpcode || bus.DMisalign) begin
                    state_d = ST_FATAL;
                end else if (bus.ERet) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HANDLER;
                end
            end
            ST_FATAL: begin
                state_d = ST_FATAL;
            end
            default: begin
                state_d = ST_IDLE;
                cause_d = CODE_NONE;
            end
        endcase
    end

    // Pending-IRQ flag and saturating drop counter update
    always_comb begin
        irq_pend_d = irq_pend_q;
        drop_d     = drop_q;
        if (state_q == ST_FATAL) begin
            irq_pend_d = irq_pend_q;
        end else if (issue_irq_s) begin
            // A fresh edge arriving as the old one issues becomes the new pending request
            irq_pend_d = irq_edge_s;
        end else if (irq_edge_s) begin
            irq_pend_d = 1'b1;
            if (irq_pend_q && (drop_q != DROP_MAX)) begin
                drop_d = drop_q + DROP_ONE;
            end else begin
                drop_d = drop_q;
            end
        end else begin
            irq_pend_d = irq_pend_q;
        end
    end

    // State, cause, pending flag and drop counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cause_q    <= CODE_NONE;
            irq_pend_q <= 1'b0;
            drop_q     <= {DROP_W{1'b0}};
        end else begin
            state_q    <= state_d;
            cause_q    <= cause_d;
            irq_pend_q <= irq_pend_d;
            drop_q     <= drop_d;
        end
    end

    assign bus.Exc        = exc_s & reset;
    assign bus.EStatus    = reset ? estatus_s : CODE_NONE;
    assign bus.InHandler  = (state_q == ST_HANDLER);
    assign bus.Fatal      = (state_q == ST_FATAL);
    assign bus.IrqDropCnt = drop_q;

endmodule

// File: tb/tb_exc_request_unit.sv
// Table-driven self-checking bench for exc_request_unit with a scoreboard of per-cycle expectations.
module tb_exc_request_unit;

    typedef struct packed {
        logic       bad;
        logic       mis;
        logic       ack;
        logic       eret;
        logic       irq;
        logic       exc;
        logic [3:0] es;
        logic       inh;
        logic       fat;
        logic [7:0] cnt;
    } vec_t;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;
    vec_t tbl[$];
    vec_t exp_q[$];

    exc_request_unit_if #(.DROP_W(8)) bus ();

    exc_request_unit #(.DROP_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    function automatic vec_t V(input logic bad, input logic mis, input logic ack,
                               input logic eret, input logic irq, input logic exc,
                               input logic [3:0] es, input logic inh, input logic fat,
                               input logic [7:0] cnt);
        vec_t v;
        v.bad = bad; v.mis = mis; v.ack = ack; v.eret = eret; v.irq = irq;
        v.exc = exc; v.es = es; v.inh = inh; v.fat = fat; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        n_total++;
        if (act == expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic chk_outputs(input string tag, input vec_t e);
        chk({tag, ".Exc"},        int'(bus.Exc),        int'(e.exc));
        chk({tag, ".EStatus"},    int'(bus.EStatus),    int'(e.es));
        chk({tag, ".InHandler"},  int'(bus.InHandler),  int'(e.inh));
        chk({tag, ".Fatal"},      int'(bus.Fatal),      int'(e.fat));
        chk({tag, ".IrqDropCnt"}, int'(bus.IrqDropCnt), int'(e.cnt));
    endtask

    // One clock cycle: drive after the rising edge, compare at the falling edge
    task automatic run(input vec_t v, input bit do_chk, input string tag);
        vec_t e;
        @(posedge clk);
        #1;
        bus.BadOpcode = v.bad;
        bus.DMisalign = v.mis;
        bus.ExcAck    = v.ack;
        bus.ERet      = v.eret;
        bus.ExtIRQ    = v.irq;
        if (do_chk) exp_q.push_back(v);
        @(negedge clk);
        if (do_chk) begin
            e = exp_q.pop_front();
            chk_outputs(tag, e);
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset         = 1'b0;
        bus.ExtIRQ    = 1'b0;
        bus.BadOpcode = 1'b1;
        bus.DMisalign = 1'b0;
        bus.ExcAck    = 1'b0;
        bus.ERet      = 1'b0;

        //     bad mis ack eret irq | exc es     inh fat cnt
        tbl.push_back(V(1,0,0,0,0, 1,4'd2,0,0,8'd0));   // 0 request held from reset release
        tbl.push_back(V(0,0,0,0,0, 1,4'd2,0,0,8'd0));
        tbl.push_back(V(0,0,1,0,0, 1,4'd2,0,0,8'd0));
        tbl.push_back(V(0,0,0,0,0, 0,4'd2,1,0,8'd0));
        tbl.push_back(V(0,0,0,1,0, 0,4'd2,1,0,8'd0));
        tbl.push_back(V(0,0,0,1,0, 0,4'd0,0,0,8'd0));   // 5 ERet in IDLE ignored
        tbl.push_back(V(0,1,1,0,0, 1,4'd3,0,0,8'd0));   // 6 same-cycle ACK
        tbl.push_back(V(0,0,0,0,0, 0,4'd3,1,0,8'd0));
        tbl.push_back(V(0,0,0,1,0, 0,4'd3,1,0,8'd0));
        tbl.push_back(V(0,0,1,0,0, 0,4'd0,0,0,8'd0));   // 9 ACK without Exc ignored
        tbl.push_back(V(0,0,0,0,1, 0,4'd0,0,0,8'd0));   // 10 IRQ rises
        tbl.push_back(V(0,0,0,0,1, 0,4'd0,0,0,8'd0));
        tbl.push_back(V(0,0,0,0,1, 0,4'd0,0,0,8'd0));
        tbl.push_back(V(1,1,0,0,1, 1,4'd2,0,0,8'd0));   // 13 all three causes, delayed ACK
        tbl.push_back(V(1,1,0,0,1, 1,4'd2,0,0,8'd0));
        tbl.push_back(V(1,1,0,0,1, 1,4'd2,0,0,8'd0));
        tbl.push_back(V(1,1,1,0,1, 1,4'd2,0,0,8'd0));
        tbl.push_back(V(0,0,0,0,1, 0,4'd2,1,0,8'd0));
        tbl.push_back(V(0,0,0,1,1, 0,4'd2,1,0,8'd0));
        tbl.push_back(V(0,0,0,0,1, 1,4'd1,0,0,8'd0));   // 19 pending IRQ issued
        tbl.push_back(V(0,0,1,0,1, 1,4'd1,0,0,8'd0));
        tbl.push_back(V(0,0,0,0,1, 0,4'd1,1,0,8'd0));
        tbl.push_back(V(0,0,0,0,0, 0,4'd1,1,0,8'd0));   // 22 IRQ pulses inside handler
        tbl.push_back(V(0,0,0,0,0, 0,4'd1,1,0,8'd0));
        tbl.push_back(V(0,0,0,0,1, 0,4'd1,1,0,8'd0));
        tbl.push_back(V(0,0,0,0,0, 0,4'd1,1,0,8'd0));
        tbl.push_back(V(0,0,0,0,1, 0,4'd1,1,0,8'd0));
        tbl.push_back(V(0,0,0,0,0, 0,4'd1,1,0,8'd0));
        tbl.push_back(V(0,0,0,0,1, 0,4'd1,1,0,8'd0));
        tbl.push_back(V(0,0,0,0,0, 0,4'd1,1,0,8'd1));
        tbl.push_back(V(0,0,0,0,0, 0,4'd1,1,0,8'd1));
        tbl.push_back(V(0,0,0,0,0, 0,4'd1,1,0,8'd2));
        tbl.push_back(V(0,0,0,1,0, 0,4'd1,1,0,8'd2));
        tbl.push_back(V(0,0,1,0,0, 1,4'd1,0,0,8'd2));   // 33 IDLE cycle after ERet
        tbl.push_back(V(0,0,0,0,0, 0,4'd1,1,0,8'd2));

        // Reset held with BadOpcode high: request must stay masked
        repeat (2) @(negedge clk);
        chk("rst.Exc",        int'(bus.Exc),        0);
        chk("rst.EStatus",    int'(bus.EStatus),    0);
        chk("rst.InHandler",  int'(bus.InHandler),  0);
        chk("rst.Fatal",      int'(bus.Fatal),      0);
        chk("rst.IrqDropCnt", int'(bus.IrqDropCnt), 0);
        #1;
        reset = 1'b1;
        #1;
        chk("rel.Exc",     int'(bus.Exc),     1);
        chk("rel.EStatus", int'(bus.EStatus), 2);

        for (int i = 0; i < tbl.size(); i++) begin
            run(tbl[i], 1'b1, $sformatf("vec[%0d]", i));
        end

        // Drop counter saturation while parked in the handler
        for (int i = 0; i < 300; i++) begin
            run(V(0,0,0,0,1, 0,4'd1,1,0,8'd0), 1'b0, "sat");
            run(V(0,0,0,0,0, 0,4'd1,1,0,8'd0), 1'b0, "sat");
        end
        repeat (3) run(V(0,0,0,0,0, 0,4'd1,1,0,8'd0), 1'b0, "sat");
        run(V(0,0,0,0,0, 0,4'd1,1,0,8'd255), 1'b1, "sat_hold");

        // Nested fault with simultaneous ERet escalates to FATAL
        run(V(1,0,0,1,0, 0,4'd1,1,0,8'd255), 1'b1, "nest0");
        run(V(1,1,1,1,1, 0,4'd1,0,1,8'd255), 1'b1, "nest1");
        run(V(0,0,0,0,0, 0,4'd1,0,1,8'd255), 1'b1, "nest2");
        run(V(0,0,0,0,0, 0,4'd1,0,1,8'd255), 1'b1, "nest3");

        // Reset out of FATAL clears the flag and loses the drop count
        reset = 1'b0;
        #2;
        chk("rst2.Fatal",      int'(bus.Fatal),      0);
        chk("rst2.Exc",        int'(bus.Exc),        0);
        chk("rst2.IrqDropCnt", int'(bus.IrqDropCnt), 0);
        @(negedge clk);
        #1;
        reset = 1'b1;

        // IRQ edge coinciding with issue of the pending IRQ: pending survives, no drop
        run(V(1,0,1,0,0, 1,4'd2,0,0,8'd0), 1'b1, "co0");
        run(V(0,0,0,0,1, 0,4'd2,1,0,8'd0), 1'b1, "co1");
        run(V(0,0,0,0,0, 0,4'd2,1,0,8'd0), 1'b1, "co2");
        run(V(0,0,0,0,0, 0,4'd2,1,0,8'd0), 1'b1, "co3");
        run(V(0,0,0,0,0, 0,4'd2,1,0,8'd0), 1'b1, "co4");
        run(V(0,0,0,0,1, 0,4'd2,1,0,8'd0), 1'b1, "co5");
        run(V(0,0,0,1,0, 0,4'd2,1,0,8'd0), 1'b1, "co6");
        run(V(0,0,0,0,0, 1,4'd1,0,0,8'd0), 1'b1, "co7");
        run(V(0,0,1,0,0, 1,4'd1,0,0,8'd0), 1'b1, "co8");
        run(V(0,0,0,0,0, 0,4'd1,1,0,8'd0), 1'b1, "co9");
        run(V(0,0,0,1,0, 0,4'd1,1,0,8'd0), 1'b1, "co10");
        run(V(0,0,0,0,0, 1,4'd1,0,0,8'd0), 1'b1, "co11");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/exc_request_unit.md
# exc_request_unit

Exception request front-end for the single-cycle LEGv8 core. It collects exception causes: an asynchronous external interrupt, plus instruction faults reported by decode and memory-address checks. It prioritises them and drives the datapath's `Exc`/`EStatus` request. It completes a request/acknowledge handshake against the datapath's `ExcAck`, blocks nesting while the handler runs, and returns to idle on `ERet`. It sits directly upstream of the datapath, in place of the controller-driven `Exc`/`EStatus` signals.

## Interface
- `DROP_W`, default 8: width of the saturating dropped-interrupt counter.
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-low; forces every register to its reset value immediately.
- `ExtIRQ`, in, 1: external interrupt, asynchronous to `clk`, level; a 0→1 edge is one request.
- `BadOpcode`, in, 1: decoder flag for the current instruction; synchronous and combinational.
- `DMisalign`, in, 1: current access has `(memRead|memWrite) && DM_addr[2:0]!=0`; synchronous.
- `ExcAck`, in, 1: datapath has loaded the vector address and captured `EStatus`.
- `ERet`, in, 1: the current instruction is ERET.
- `Exc`, out, 1: exception request to the datapath.
- `EStatus`, out, 4: cause code. 4'b0000 none, 4'b0001 ExtIRQ, 4'b0010 BadOpcode, 4'b0011 DMisalign.
- `InHandler`, out, 1: handler is executing (state HANDLER).
- `Fatal`, out, 1: sticky flag for a fault raised inside the handler; core must halt.
- `IrqDropCnt`, out, DROP_W: count of IRQ edges lost because one was already pending.

## Operation
- **IRQ path**
  - `ExtIRQ` passes through a 2-flop synchronizer, then a rising-edge detector on the synchronized level.
  - An edge sets `irq_pend`.
  - An edge while `irq_pend` is already 1 increments `IrqDropCnt`, saturating at all-ones.
- **Priority** (highest first): BadOpcode, DMisalign, `irq_pend`. Synchronous faults are precise: they reach `Exc` combinationally in the same cycle.
- **States:** IDLE, REQ, HANDLER, FATAL.
- **IDLE**
  - `Exc = BadOpcode | DMisalign | irq_pend`.
  - `EStatus` = code of the highest-priority active cause, else 0.
  - `Exc` && `ExcAck` → HANDLER.
  - `Exc` && !`ExcAck` → REQ, latching the winning code in `cause_q`.
  - If the winning cause is the IRQ, `irq_pend` clears when the code is committed (on the ACK, or on entry to REQ).
- **REQ**
  - `Exc=1`, `EStatus=cause_q`.
  - New synchronous faults are ignored; the request already stalls the instruction.
  - `ExcAck` → HANDLER.
- **HANDLER**
  - `Exc=0`, `EStatus=cause_q`, `InHandler=1`.
  - IRQ edges set `irq_pend` but are not issued.
  - `ERet` → IDLE; a pending IRQ is then requested in the IDLE cycle that follows.
  - `BadOpcode` or `DMisalign` → FATAL. This takes precedence over a simultaneous `ERet`.
- **FATAL**
  - `Fatal=1`, `Exc=0`, `EStatus=cause_q`.
  - All inputs are ignored; the only exit is reset.
- `ERet` outside HANDLER and `ExcAck` while `Exc=0` are ignored.

## Timing
- Reset values:
  - state IDLE, `cause_q=0`, `irq_pend=0`, synchronizer flops 0, `IrqDropCnt=0`.
  - Outputs during and after reset: `Exc=0`, `EStatus=0`, `InHandler=0`, `Fatal=0`.
  - While reset is asserted, `Exc` is forced to 0 even if fault inputs are high.
- Synchronous fault to `Exc`: 0 cycles (combinational).
- IRQ latency: from `ExtIRQ` rising before edge k, `irq_pend=1` after edge k+2 and `Exc=1` in that same cycle.
- Handshake:
  - `Exc` stays high with a stable `EStatus` until the cycle `ExcAck=1` is sampled.
  - `InHandler` rises on the following edge.
- HANDLER → IDLE on the edge sampling `ERet`. A pending IRQ re-asserts `Exc` in the next cycle, so there are no back-to-back handler entries without at least one IDLE cycle.
- Reset mid-REQ or mid-HANDLER: immediate return to IDLE; the pending IRQ and drop count are lost.
- Simultaneous IRQ edge and issue of that same pending IRQ: `irq_pend` stays 1 and `IrqDropCnt` is unchanged.

## Test plan
- **Reset:** deassert `reset` with `BadOpcode=1` held high. During reset `Exc=0` and `EStatus=0`; one cycle after release `Exc=1` and `EStatus=0010`.
- **Precise fault with same-cycle ACK:** in IDLE, `DMisalign=1` and `ExcAck=1` in one cycle. In that cycle `Exc=1`, `EStatus=0011`. Next cycle `InHandler=1`, `Exc=0`. After `ERet`: IDLE, `InHandler=0`.
- **Delayed ACK plus priority:** `BadOpcode=1`, `DMisalign=1`, `irq_pend=1`, `ExcAck=0` for 3 cycles, then 1. `EStatus=0010` throughout. Afterwards `irq_pend` is still 1, and after `ERet` `EStatus=0001` is requested.
- **IRQ in handler:**
  - Pulse `ExtIRQ` while in HANDLER. `Exc` stays 0.
  - After `ERet`, the IDLE cycle shows `Exc=1`, `EStatus=0001`.
  - Three pulses while pending give `IrqDropCnt=2`.
  - Issue more than 255 drops with `DROP_W=8`; the counter holds at 255.
- **Nested fault:** `BadOpcode=1` together with `ERet=1` while in HANDLER. Result: FATAL, `Fatal=1`, `Exc=0`, no further requests until reset; reset clears `Fatal`.
